// File: rtl/lcb_rx_collector.sv
// N-channel LCB receive collector: per-channel byte FIFOs, packet counting and round-robin packet drain.
// Optional inter-byte timeout enabled by defining LCB_RX_TIMEOUT_EN.
module lcb_rx_collector #(
    parameter int NCH        = 5,
    parameter int PKT_LEN    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 800,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int IDXW      = $clog2(PKT_LEN),
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    iValid,
    input  logic [NCH*8-1:0]  iData,
    input  logic              iFlush,
    input  logic              iBusy,
    output logic              oStrob,
    output logic [7:0]        oData,
    output logic [CHW-1:0]    oCh,
    output logic [IDXW-1:0]   oIdx,
    output logic              oLast,
    output logic [NCH-1:0]    oPend,
    output logic [NCH-1:0]    oOvf,
    output logic [NCH-1:0]    oTmo
);

    if (NCH < 1 || NCH > 16 || PKT_LEN < 2 || PKT_LEN > FIFO_DEPTH ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : gBadParams
        $error("lcb_rx_collector: illegal parameter set");
    end

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PKT_LEN - 1);
    localparam logic [AW:0]     FULL_LVL = FIFO_DEPTH[AW:0];

    typedef enum logic {IDLE, SEND} stateT;

    logic [7:0]      mem      [NCH][FIFO_DEPTH];
    logic [AW:0]     wptr     [NCH];
    logic [AW:0]     rptr     [NCH];
    logic [AW:0]     pstart   [NCH];
    logic [AW:0]     pcnt     [NCH];
    logic [AW:0]     pcntNext [NCH];
    logic [IDXW-1:0] bcnt     [NCH];
    logic [NCH-1:0]  full, pktDone, pktTaken, rewind, tmoHit;

    stateT           state, stateNext;
    logic [CHW-1:0]  grant, grantNext, rrPtr, rrNext;
    logic [IDXW-1:0] sendIdx;
    logic            issue, lastByte, found;
    int              cand;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        full     = '0;
        pktDone  = '0;
        pktTaken = '0;
        rewind   = '0;
        for (int k = 0; k < NCH; k++) begin
            full[k]     = (wptr[k] - rptr[k]) == FULL_LVL;
            pktDone[k]  = !iFlush && iValid[k] && !full[k] && (bcnt[k] == LAST_IDX);
            pktTaken[k] = issue && lastByte && (grant == CHW'(k));
            rewind[k]   = iFlush || (iValid[k] && full[k]) || tmoHit[k];
            pcntNext[k] = pcnt[k] + {{AW{1'b0}}, pktDone[k]} - {{AW{1'b0}}, pktTaken[k]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) begin
                wptr[k]   <= '0;
                rptr[k]   <= '0;
                pstart[k] <= '0;
                pcnt[k]   <= '0;
                bcnt[k]   <= '0;
            end
            oOvf  <= '0;
            oPend <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (rewind[k]) begin
                    wptr[k] <= pstart[k];
                    bcnt[k] <= '0;
                end else if (iValid[k]) begin
                    wptr[k] <= wptr[k] + 1'b1;
                    if (bcnt[k] == LAST_IDX) begin
                        bcnt[k]   <= '0;
                        pstart[k] <= wptr[k] + 1'b1;
                    end else begin
                        bcnt[k] <= bcnt[k] + 1'b1;
                    end
                end
                if (!iFlush && iValid[k] && full[k])
                    oOvf[k] <= 1'b1;
                if (issue && grant == CHW'(k))
                    rptr[k] <= rptr[k] + 1'b1;
                pcnt[k]  <= pcntNext[k];
                oPend[k] <= (pcntNext[k] != '0);
            end
        end
    end

    // NOTE: the byte storage has no reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (!iFlush && iValid[k] && !full[k])
                mem[k][wptr[k][AW-1:0]] <= iData[8*k +: 8];
        end
    end

    always_comb begin
        stateNext = state;
        grantNext = grant;
        rrNext    = rrPtr;
        issue     = 1'b0;
        lastByte  = (sendIdx == LAST_IDX);
        found     = 1'b0;
        cand      = 0;
        case (state)
            IDLE: begin
                // Search starts at rrPtr, which always points one past the last grant.
                for (int i = 0; i < NCH; i++) begin
                    cand = int'(rrPtr) + i;
                    if (cand >= NCH)
                        cand = cand - NCH;
                    if (!found && pcnt[cand] != '0) begin
                        found     = 1'b1;
                        grantNext = CHW'(cand);
                    end
                end
                if (found) begin
                    stateNext = SEND;
                    rrNext    = (grantNext == CHW'(NCH - 1)) ? '0 : grantNext + 1'b1;
                end
            end
            SEND: begin
                if (!iBusy) begin
                    issue = 1'b1;
                    if (lastByte)
                        stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant   <= '0;
            rrPtr   <= '0;
            sendIdx <= '0;
            oStrob  <= 1'b0;
            oData   <= '0;
            oCh     <= '0;
            oIdx    <= '0;
            oLast   <= 1'b0;
        end else begin
            state  <= stateNext;
            grant  <= grantNext;
            rrPtr  <= rrNext;
            oStrob <= issue;
            oLast  <= issue && lastByte;
            if (state == IDLE)
                sendIdx <= '0;
            else if (issue)
                sendIdx <= sendIdx + 1'b1;
            if (issue) begin
                oData <= mem[grant][rptr[grant][AW-1:0]];
                oCh   <= grant;
                oIdx  <= sendIdx;
            end
        end
    end

`ifdef LCB_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmoCnt [NCH];

    always_comb begin
        tmoHit = '0;
        for (int k = 0; k < NCH; k++)
            tmoHit[k] = !iFlush && !iValid[k] && (bcnt[k] != '0) && (tmoCnt[k] == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++)
                tmoCnt[k] <= '0;
            oTmo <= '0;
        end else begin
            oTmo <= tmoHit;
            for (int k = 0; k < NCH; k++) begin
                if (iFlush || iValid[k] || tmoHit[k] || bcnt[k] == '0)
                    tmoCnt[k] <= '0;
                else
                    tmoCnt[k] <= tmoCnt[k] + 1'b1;
            end
        end
    end
`else
    assign tmoHit = '0;
    assign oTmo   = '0;
`endif

endmodule
